// File: rtl/patcolor.sv
// patcolor: pixel pattern engine turning syncgen raster timing into registered DE and 24-bit RGB.
// Four patterns (colour bars, gray ramp, grid, scrolling checkerboard); geometry follows RESOL.
module patcolor (
    input  logic        DCLK,
    input  logic        DRST,
    input  logic [1:0]  RESOL,
    input  logic [1:0]  PATSEL,
    input  logic [10:0] HCNT,
    input  logic [10:0] VCNT,
    input  logic        DSP_preDE,
    output logic        DSP_DE,
    output logic [7:0]  DSP_R,
    output logic [7:0]  DSP_G,
    output logic [7:0]  DSP_B
);
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic [5:0]  r_off;
    logic [1:0]  r_pat;
    logic [7:0]  r_bsub;
    logic [2:0]  r_bidx;
    logic        r_act_d;
    logic        r_run;
    logic        r_de;
    logic [23:0] r_rgb;
    logic        w_fs;
    logic        w_act;
    logic [7:0]  w_bar_last;
    logic [10:0] w_wm1;
    logic [10:0] w_hm1;
    logic [7:0]  w_gray;
    logic        w_grid;
    logic        w_chk;
    logic [23:0] w_color;
    assign w_fs  = (HCNT == 11'd0) && (VCNT == 11'd0);
    // After a reset the engine waits for a blanking cycle so output restarts on a clean line at x=0.
    assign w_act = DSP_preDE & r_run;
    always_comb begin
        w_bar_last = 8'd79;
        w_wm1      = 11'd639;
        w_hm1      = 11'd479;
        case (RESOL)
            2'd1: begin
                w_bar_last = 8'd99;
                w_wm1      = 11'd799;
                w_hm1      = 11'd599;
            end
            2'd2: begin
                w_bar_last = 8'd127;
                w_wm1      = 11'd1023;
                w_hm1      = 11'd767;
            end
            2'd3: begin
                w_bar_last = 8'd159;
                w_wm1      = 11'd1279;
                w_hm1      = 11'd1023;
            end
            default: ;
        endcase
    end
    assign w_gray = (RESOL == 2'd3) ? r_x[10:3] : r_x[9:2];
    assign w_grid = (r_x[4:0] == 5'd0) || (r_y[4:0] == 5'd0) || (r_x == w_wm1) || (r_y == w_hm1);
    // Bit 6 of (x + offset) only depends on the low seven bits of x.
    assign w_chk  = (7'(r_x[6:0] + {1'b0, r_off}) >= 7'd64) ^ r_y[6];
    always_comb begin
        w_color = (r_pat == 2'd1) ? {3{w_gray}} :
                  (r_pat == 2'd2) ? (w_grid ? 24'hFFFFFF : 24'h000000) :
                  (r_pat == 2'd3) ? (w_chk ? 24'hFFFFFF : 24'h404040) :
                  {{8{~r_bidx[1]}}, {8{~r_bidx[2]}}, {8{~r_bidx[0]}}};
    end
    always_ff @(posedge DCLK) begin
        if (DRST) begin
            r_x     <= 11'd0;
            r_y     <= 11'd0;
            r_off   <= 6'd0;
            r_pat   <= 2'd0;
            r_bsub  <= 8'd0;
            r_bidx  <= 3'd0;
            r_act_d <= 1'b0;
            r_run   <= 1'b0;
            r_de    <= 1'b0;
            r_rgb   <= 24'd0;
        end else begin
            r_run   <= r_run | ~DSP_preDE;
            r_act_d <= w_act;
            r_x     <= w_act ? r_x + 11'd1 : 11'd0;
            if (!w_act) begin
                r_bsub <= 8'd0;
                r_bidx <= 3'd0;
            end else if (r_bsub == w_bar_last) begin
                r_bsub <= 8'd0;
                r_bidx <= (r_bidx == 3'd7) ? 3'd7 : r_bidx + 3'd1;
            end else begin
                r_bsub <= r_bsub + 8'd1;
            end
            if (w_fs) begin
                r_y   <= 11'd0;
                r_pat <= PATSEL;
                r_off <= r_off + 6'd1;
            end else if (r_act_d && !w_act) begin
                r_y <= r_y + 11'd1;
            end
            r_de  <= w_act;
            r_rgb <= w_act ? w_color : 24'd0;
        end
    end
    assign DSP_DE = r_de;
    assign DSP_R  = r_rgb[23:16];
    assign DSP_G  = r_rgb[15:8];
    assign DSP_B  = r_rgb[7:0];
endmodule

// File: tb/tb_patcolor.sv
// tb_patcolor: directed raster stimulus with a queued scoreboard checked by an independent monitor.
module tb_patcolor;
    logic        clk = 1'b0;
    logic        rst;
    logic        pde;
    logic [1:0]  resol;
    logic [1:0]  patsel;
    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic        de;
    logic [7:0]  r, g, b;
    always #5 clk = ~clk;
    patcolor dut (
        .DCLK(clk), .DRST(rst), .RESOL(resol), .PATSEL(patsel),
        .HCNT(hcnt), .VCNT(vcnt), .DSP_preDE(pde),
        .DSP_DE(de), .DSP_R(r), .DSP_G(g), .DSP_B(b)
    );
    typedef struct {
        int          due;
        logic        de;
        logic [23:0] rgb;
        string       nm;
    } exp_t;
    exp_t  q[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    int    pat, off, res;
    string nm;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [23:0] bar_col(input int idx);
        logic [23:0] c;
        case (idx)
            0: c = 24'hFFFFFF;
            1: c = 24'hFFFF00;
            2: c = 24'h00FFFF;
            3: c = 24'h00FF00;
            4: c = 24'hFF00FF;
            5: c = 24'hFF0000;
            6: c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction
    function automatic logic [23:0] ref_pix(input int p, input int rs, input int x, input int y, input int o);
        int w, h, idx, gv;
        logic [7:0] gb;
        logic [23:0] c;
        w = (rs == 0) ? 640 : (rs == 1) ? 800 : (rs == 2) ? 1024 : 1280;
        h = (rs == 0) ? 480 : (rs == 1) ? 600 : (rs == 2) ? 768 : 1024;
        case (p)
            0: begin
                idx = x / (w / 8);
                if (idx > 7) idx = 7;
                c = bar_col(idx);
            end
            1: begin
                gv = (x >> ((rs == 3) ? 3 : 2)) % 256;
                gb = gv[7:0];
                c = {gb, gb, gb};
            end
            2: c = ((x % 32 == 0) || (y % 32 == 0) || (x == w - 1) || (y == h - 1)) ? 24'hFFFFFF : 24'h000000;
            default: c = (((((x + o) / 64) % 2) ^ ((y / 64) % 2)) != 0) ? 24'hFFFFFF : 24'h404040;
        endcase
        return c;
    endfunction
    task automatic tick(input bit rs, input bit p, input int h, input int v, input bit ede, input logic [23:0] ergb);
        exp_t e;
        @(posedge clk);
        #1;
        rst  = rs;
        pde  = p;
        hcnt = h[10:0];
        vcnt = v[10:0];
        e.due = cyc + 1;
        e.de  = ede;
        e.rgb = ergb;
        e.nm  = nm;
        q.push_back(e);
    endtask
    task automatic do_reset(input int rr, input int ps);
        resol  = rr[1:0];
        patsel = ps[1:0];
        res    = rr;
        repeat (3) tick(1, 0, 1, 1, 0, 24'd0);
        pat = 0;
        off = 0;
    endtask
    task automatic fstart();
        tick(0, 0, 0, 0, 0, 24'd0);
        pat = int'(patsel);
        off = (off + 1) % 64;
    endtask
    task automatic line(input int v, input int y, input int len);
        for (int i = 0; i < 4; i++) tick(0, 0, i + 1, v, 0, 24'd0);
        for (int i = 0; i < len; i++)
            tick(0, 1, (i + 5) % 2048, v, 1, ref_pix(pat, res, i % 2048, y, off));
        for (int i = 0; i < 3; i++) tick(0, 0, (len + 5 + i) % 2048, v, 0, 24'd0);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.due != cyc || de !== e.de || {r, g, b} !== e.rgb) begin
                    failures++;
                    $display("FAIL %s cyc=%0d due=%0d got de=%b rgb=%h expected de=%b rgb=%h",
                             e.nm, cyc, e.due, de, {r, g, b}, e.de, e.rgb);
                end
            end
        end
    end
    initial begin
        rst = 1'b1; pde = 1'b0; hcnt = 11'd1; vcnt = 11'd1; resol = 2'd0; patsel = 2'd0;
        pat = 0; off = 0; res = 0;
        nm = "reset_state";
        do_reset(0, 0);
        nm = "bars_r0";
        fstart();
        line(1, 0, 640);
        line(2, 1, 640);
        nm = "patsel_midframe";
        patsel = 2'd1;
        line(3, 2, 640);
        fstart();
        nm = "gray_r0";
        line(1, 0, 640);
        nm = "bars_until_fstart";
        do_reset(0, 1);
        line(1, 0, 640);
        nm = "grid_r1";
        do_reset(1, 2);
        fstart();
        line(1, 0, 800);
        line(2, 1, 800);
        for (int y = 2; y < 599; y++) line(y + 1, y, 8);
        nm = "grid_last_row";
        line(600, 599, 40);
        nm = "checker";
        do_reset(0, 3);
        fstart();
        for (int y = 0; y < 65; y++) line(y + 1, y, 140);
        nm = "checker_wrap64";
        repeat (63) fstart();
        line(1, 0, 640);
        nm = "gray_xwrap";
        do_reset(0, 1);
        fstart();
        line(1, 0, 2052);
        nm = "bars_saturate";
        patsel = 2'd0;
        fstart();
        line(1, 0, 700);
        nm = "gray_r3";
        do_reset(3, 1);
        fstart();
        line(1, 0, 1280);
        nm = "drst_midline";
        do_reset(0, 3);
        fstart();
        for (int i = 0; i < 4; i++) tick(0, 0, i + 1, 1, 0, 24'd0);
        for (int i = 0; i < 200; i++) tick(0, 1, i + 5, 1, 1, ref_pix(pat, res, i, 0, off));
        tick(1, 1, 205, 1, 0, 24'd0);
        pat = 0;
        off = 0;
        for (int i = 0; i < 100; i++) tick(0, 1, i + 206, 1, 0, 24'd0);
        for (int i = 0; i < 3; i++) tick(0, 0, i + 306, 1, 0, 24'd0);
        nm = "after_drst";
        line(2, 0, 640);
        repeat (4) @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
